// File: rtl/fd_stage.sv
// Fetch/decode pipeline latch: captures PC/instruction with flush > stall > load
// priority, decodes fields and regfile read addresses, and keeps saturating counters.
module fd_stage #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic [31:0]          instr_in,
    input  logic                 stall,
    input  logic                 flush,
    output logic [PC_WIDTH-1:0]  fd_pc,
    output logic [31:0]          fd_instr,
    output logic                 fd_valid,
    output logic [4:0]           opcode,
    output logic [4:0]           rd,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           shamt,
    output logic [4:0]           alu_op,
    output logic [31:0]          imm_sx,
    output logic [31:0]          target,
    output logic [4:0]           ctrl_readRegA,
    output logic [4:0]           ctrl_readRegB,
    output logic                 illegal_instr,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d, bcnt_q, bcnt_d;
    logic                 load;

    assign load = !flush && !stall;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = pc_in;
            instr_d = 32'h0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
        // Counters stick at all-ones rather than wrapping.
        fcnt_d = (load && fcnt_q != '1) ? fcnt_q + 1'b1 : fcnt_q;
        bcnt_d = ((stall || flush) && bcnt_q != '1) ? bcnt_q + 1'b1 : bcnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign fd_pc        = pc_q;
    assign fd_instr     = instr_q;
    assign fd_valid     = valid_q;
    assign fetch_count  = fcnt_q;
    assign bubble_count = bcnt_q;

    assign opcode = instr_q[31:27];
    assign rd     = instr_q[26:22];
    assign rs     = instr_q[21:17];
    assign rt     = instr_q[16:12];
    assign shamt  = instr_q[11:7];
    assign alu_op = instr_q[6:2];
    assign imm_sx = {{15{instr_q[16]}}, instr_q[16:0]};
    assign target = {5'b0, instr_q[26:0]};

    always_comb begin
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        illegal_instr = 1'b0;
        if (valid_q) begin
            case (opcode)
                5'b00000: begin ctrl_readRegA = rs; ctrl_readRegB = rt; end
                5'b00101,
                5'b01000: ctrl_readRegA = rs;
                5'b00111: begin ctrl_readRegA = rs; ctrl_readRegB = rd; end
                5'b00010,
                5'b00110: begin ctrl_readRegA = rd; ctrl_readRegB = rs; end
                5'b00100: ctrl_readRegA = rd;
                5'b10110: ctrl_readRegB = 5'd30;
                5'b00001,
                5'b00011,
                5'b10101: ;
                default:  illegal_instr = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fd_stage.sv
// Scoreboarded random + directed bench for fd_stage; also runs a CNT_WIDTH=4 copy
// to exercise counter saturation.
module tb_fd_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_in, instr_in;
    logic        stall, flush;

    logic [31:0] fd_pc, fd_instr, imm_sx, target, fetch_count, bubble_count;
    logic        fd_valid, illegal_instr;
    logic [4:0]  opcode, rd, rs, rt, shamt, alu_op, ra, rb;

    logic [31:0] fd_pc4, fd_instr4, imm_sx4, target4;
    logic        fd_valid4, illegal4;
    logic [4:0]  opcode4, rd4, rs4, rt4, shamt4, alu_op4, ra4, rb4;
    logic [3:0]  fcnt4, bcnt4;

    always #5 clock = ~clock;

    fd_stage dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush), .fd_pc(fd_pc), .fd_instr(fd_instr),
        .fd_valid(fd_valid), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .shamt(shamt), .alu_op(alu_op), .imm_sx(imm_sx), .target(target),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb), .illegal_instr(illegal_instr),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    fd_stage #(.CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush), .fd_pc(fd_pc4), .fd_instr(fd_instr4),
        .fd_valid(fd_valid4), .opcode(opcode4), .rd(rd4), .rs(rs4), .rt(rt4),
        .shamt(shamt4), .alu_op(alu_op4), .imm_sx(imm_sx4), .target(target4),
        .ctrl_readRegA(ra4), .ctrl_readRegB(rb4), .illegal_instr(illegal4),
        .fetch_count(fcnt4), .bubble_count(bcnt4)
    );

    typedef struct {
        logic [31:0] pc, instr;
        logic        v;
        logic [4:0]  a, b;
        logic        ill;
        longint      fc, bc;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0, checks = 0;

    // Reference architectural state
    logic [31:0] m_pc, m_instr;
    logic        m_v;
    longint      m_fetch, m_bubble;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Read-port table taken straight from the opcode list
    function automatic void ref_ports(input logic [31:0] ins, input logic v,
                                      output logic [4:0] a, output logic [4:0] b,
                                      output logic ill);
        logic [4:0] op, f_rd, f_rs, f_rt;
        op = ins[31:27]; f_rd = ins[26:22]; f_rs = ins[21:17]; f_rt = ins[16:12];
        a = 0; b = 0; ill = 0;
        if (!v) return;
        if (op == 5'd0)                       begin a = f_rs; b = f_rt; end
        else if (op == 5'd5 || op == 5'd8)    a = f_rs;
        else if (op == 5'd7)                  begin a = f_rs; b = f_rd; end
        else if (op == 5'd2 || op == 5'd6)    begin a = f_rd; b = f_rs; end
        else if (op == 5'd4)                  a = f_rd;
        else if (op == 5'd22)                 b = 5'd30;
        else if (op == 5'd1 || op == 5'd3 || op == 5'd21) ;
        else                                  ill = 1;
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (64'sd1 <<< w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_v = 0; m_fetch = 0; m_bubble = 0;
    endtask

    task automatic step(input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
        exp_t e;
        pc_in = pc; instr_in = ins; stall = st; flush = fl;
        @(posedge clock);
        if (fl) begin
            m_pc = pc; m_instr = 0; m_v = 0;
        end else if (!st) begin
            m_pc = pc; m_instr = ins; m_v = 1; m_fetch++;
        end
        if (st || fl) m_bubble++;
        e.pc = m_pc; e.instr = m_instr; e.v = m_v; e.fc = m_fetch; e.bc = m_bubble;
        ref_ports(m_instr, m_v, e.a, e.b, e.ill);
        sb.push_back(e);
        @(negedge clock);
    endtask

    // Monitor: every edge after reset release presents a new latch state.
    initial begin
        exp_t e;
        logic [31:0] exp_imm;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                exp_imm = e.instr[16] ? (32'(e.instr[16:0]) - 32'h2_0000) : 32'(e.instr[16:0]);
                chk("fd_pc", fd_pc, e.pc);
                chk("fd_instr", fd_instr, e.instr);
                chk("fd_valid", fd_valid, e.v);
                chk("fields", {opcode, rd, rs, rt, shamt, alu_op}, e.instr[31:2]);
                chk("imm_sx", imm_sx, exp_imm);
                chk("target", target, e.instr % (32'h1 << 27));
                chk("readA", ra, e.a);
                chk("readB", rb, e.b);
                chk("illegal", illegal_instr, e.ill);
                chk("fetch_count", fetch_count, sat(e.fc, 32));
                chk("bubble_count", bubble_count, sat(e.bc, 32));
                chk("fetch_count4", fcnt4, sat(e.fc, 4));
                chk("bubble_count4", bcnt4, sat(e.bc, 4));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    logic [4:0] ops [0:12] = '{5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4,
                               5'd22, 5'd1, 5'd3, 5'd21, 5'd31, 5'd12};

    initial begin
        reset = 0; pc_in = 0; instr_in = 0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_pc", fd_pc, 0);
        chk("rst_instr", fd_instr, 0);
        chk("rst_valid", fd_valid, 0);
        chk("rst_ports", {ra, rb, illegal_instr}, 0);
        chk("rst_counts", {fetch_count, bubble_count}, 0);
        reset = 1;

        // addi r3,r2,3
        step(5, 32'h28C4_0003, 0, 0);
        chk("addi_rs", rs, 2);
        chk("addi_imm", imm_sx, 3);
        // blt r4,r7 with all-ones immediate
        step(6, {5'b00110, 5'd4, 5'd7, 17'h1FFFF}, 0, 0);
        chk("blt_imm", imm_sx, 32'hFFFF_FFFF);
        // stall hold, then resume
        step(8, 32'h28C4_0003, 0, 0);
        for (int i = 0; i < 3; i++) step(9 + i, $urandom, 1, 0);
        chk("stall_pc", fd_pc, 8);
        chk("stall_bubbles", bubble_count, 3);
        step(12, {5'd0, 5'd1, 5'd2, 5'd3, 12'h0}, 0, 0);
        chk("resume_pc", fd_pc, 12);
        // flush beats stall
        step(13, 32'h28C4_0003, 1, 1);
        chk("flush_bubbles", bubble_count, 4);
        // illegal opcode then bex
        step(14, {5'b11111, 27'h123_4567}, 0, 0);
        chk("illegal_hi", illegal_instr, 1);
        step(15, {5'b10110, 27'h0}, 0, 0);
        chk("bex_b", rb, 30);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:27] = ops[$urandom_range(0, 12)];
            step($urandom, ins, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
        end

        for (int i = 0; i < 20; i++) step(i, 32'h0, 0, 0);
        chk("sat4_fetch", fcnt4, 15);

        // Async reset between edges with an R-type latched
        step(100, {5'd0, 5'd9, 5'd10, 5'd11, 12'h0}, 0, 0);
        #2;
        reset = 0;
        #1;
        chk("async_instr", fd_instr, 0);
        chk("async_valid", fd_valid, 0);
        chk("async_pc", fd_pc, 0);
        chk("async_ports", {ra, rb}, 0);
        chk("async_counts", {fetch_count, bubble_count, fcnt4, bcnt4}, 0);
        model_reset();
        @(negedge clock);
        reset = 1;
        step(200, 32'h28C4_0003, 0, 0);
        step(201, 32'h0, 1, 0);

        @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fd_stage.md
Name: fd_stage

Overview:
- Fetch/decode pipeline latch directly downstream of the program-counter/fetch logic in the 5-stage processor.
- Captures the fetched PC and instruction word each cycle, with stall and flush control.
- Decodes the latched word into instruction fields and register-file read addresses, which feed `ctrl_readRegA` and `ctrl_readRegB`.
- Keeps saturating fetch and bubble performance counters.

Parameters:
- PC_WIDTH, 32, width of the PC values carried through the latch.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clock  input  1  master clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_in  input  PC_WIDTH  PC of the instruction presented this cycle; the fetch stage's current address_imem.
- instr_in  input  32  instruction word (q_imem) for pc_in.
- stall  input  1  hold the latch contents (load-use or multdiv hazard).
- flush  input  1  squash the latch to a bubble (taken branch or jump).
- fd_pc  output  PC_WIDTH  latched PC.
- fd_instr  output  32  latched instruction; 32'h0 (nop) when bubbled.
- fd_valid  output  1  latched instruction is real, not a bubble.
- opcode  output  5  fd_instr[31:27].
- rd  output  5  fd_instr[26:22].
- rs  output  5  fd_instr[21:17].
- rt  output  5  fd_instr[16:12].
- shamt  output  5  fd_instr[11:7].
- alu_op  output  5  fd_instr[6:2].
- imm_sx  output  32  fd_instr[16:0] sign-extended.
- target  output  32  fd_instr[26:0] zero-extended.
- ctrl_readRegA  output  5  regfile port-A read address.
- ctrl_readRegB  output  5  regfile port-B read address.
- illegal_instr  output  1  fd_valid and the opcode is not in the decode list.
- fetch_count  output  CNT_WIDTH  number of instructions captured.
- bubble_count  output  CNT_WIDTH  number of cycles with stall or flush asserted.

Behaviour:
- Reset (reset==0, asynchronous): fd_pc=0, fd_instr=0, fd_valid=0, fetch_count=0, bubble_count=0.
  - All decoded outputs therefore equal the decode of 32'h0.
  - Reset mid-stall or mid-flush discards everything.
  - The first capture happens on the first rising edge with reset==1.
- Per rising edge, priority is flush > stall > load:
  - flush=1: fd_instr<=0, fd_valid<=0, fd_pc<=pc_in. Flush wins when stall=1 at the same time.
  - flush=0, stall=1: fd_pc, fd_instr and fd_valid all hold.
  - otherwise: fd_pc<=pc_in, fd_instr<=instr_in, fd_valid<=1.
- Latency: one cycle from pc_in/instr_in to fd_*.
- Decode is purely combinational from the latched fd_instr; no extra latency.
- Field outputs are always a straight slice or extension of fd_instr, whatever fd_valid is.
- Read-address selection by opcode:
  - 00000 R-type: A=rs, B=rt.
  - 00101 addi, 01000 lw: A=rs, B=0.
  - 00111 sw: A=rs, B=rd.
  - 00010 bne, 00110 blt: A=rd, B=rs.
  - 00100 jr: A=rd, B=0.
  - 10110 bex: A=0, B=30.
  - 00001 j, 00011 jal, 10101 setx: A=0, B=0.
  - any other opcode: A=0, B=0, and illegal_instr=fd_valid.
  - fd_valid=0: A=0, B=0, illegal_instr=0.
- fetch_count increments by 1 on each edge that performs a load.
- bubble_count increments by 1 on each edge with stall|flush=1 (counts once even if both are set).
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset then load: release reset with pc_in=5, instr_in=32'h28C4_0003 (addi r3,r2,3), then 1 edge -> fd_pc=5, fd_valid=1, opcode=00101, rd=3, rs=2, imm_sx=3, readA=2, readB=0, fetch_count=1.
- Sign extension and branch read ports: load blt with fd_instr[16:0]=17'h1FFFF, rd=4, rs=7 -> imm_sx=32'hFFFF_FFFF, readA=4, readB=7.
- Stall hold then resume: load PC 8, then assert stall for 3 edges with pc_in changing -> fd_pc stays 8, bubble_count=3. Deassert stall -> next pc_in is captured.
- Flush versus stall: flush=1 and stall=1 on the same edge -> fd_instr=0, fd_valid=0, readA=readB=0, bubble_count increments by exactly 1.
- Illegal opcode and bex: load opcode 11111 -> illegal_instr=1, readA=readB=0. Load bex -> readA=0, readB=30, illegal_instr=0.
- Async reset mid-operation: assert reset between edges while a valid R-type is latched -> outputs clear immediately, with no clock edge needed; counters=0. Separately, preload fetch_count to all-ones via a reduced CNT_WIDTH=4 build and do 20 loads -> count holds at 15.
